// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: operation modes, FSM states
// and a helper that classifies the pass-through modes.
// Latency: n/a (definitions only). Backpressure: n/a.
package shifter_pkg;

    // Operation encodings carried on MODE; 101..111 all mean pass-through.
    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    // Any encoding above ROR leaves the operand untouched.
    function automatic logic is_pass(input logic [2:0] mode);
        return (mode > MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Fixed-distance combinational shifter: moves data by S bits in the given mode.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: data_i (W) operand, mode_i (3) operation, data_o (W) shifted result.
module shift_step
    import shifter_pkg::*;
#(
    parameter int W = 32,
    parameter int S = 2
) (
    input  logic [W-1:0] data_i,
    input  logic [2:0]   mode_i,
    output logic [W-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (mode_i)
            MODE_LSL: data_o = data_i << S;
            MODE_LSR: data_o = data_i >> S;
            // Sign bit replicates into every vacated position.
            MODE_ASR: data_o = W'($signed(data_i) >>> S);
            MODE_ROL: data_o = (data_i << S) | (data_i >> (W - S));
            MODE_ROR: data_o = (data_i >> S) | (data_i << (W - S));
            default:  data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shifter_iter.sv
// Iterative shifter: LSL/LSR/ASR/ROL/ROR by AMT using STEP-bit coarse steps,
// then 1-bit steps. Latency: DONE at accept+1+floor(AMT/STEP)+(AMT mod STEP).
// Backpressure: START is ignored while BUSY; no queuing, back-to-back from FIN.
// Ports: CLK, RST_N (sync, active-low); START/IN/AMT/MODE request sampled on
// accept; BUSY high in SHIFT; DONE one-cycle pulse in FIN; OUT result register.
module shifter_iter
    import shifter_pkg::*;
#(
    parameter int W    = 32,
    parameter int STEP = 2,
    parameter int AW   = $clog2(W)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [W-1:0]  IN,
    input  logic [AW-1:0] AMT,
    input  logic [2:0]    MODE,
    output logic          BUSY,
    output logic          DONE,
    output logic [W-1:0]  OUT
);

    localparam logic [AW-1:0] STEP_A = AW'(STEP);
    localparam logic [AW-1:0] ONE_A  = AW'(1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [2:0]    mode_q, mode_d;
    logic [W-1:0]  out_q, out_d;

    logic [W-1:0]  coarse_dat;
    logic [W-1:0]  fine_dat;

    shift_step #(.W(W), .S(STEP)) u_coarse (
        .data_i (out_q),
        .mode_i (mode_q),
        .data_o (coarse_dat)
    );

    shift_step #(.W(W), .S(1)) u_fine (
        .data_i (out_q),
        .mode_i (mode_q),
        .data_o (fine_dat)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (START) begin
                    out_d  = IN;
                    rem_d  = AMT;
                    mode_d = MODE;
                    // Nothing to iterate: go straight to the done pulse.
                    state_d = (AMT == '0 || is_pass(MODE)) ? ST_FIN : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Coarse steps while they fit, then single-bit steps for the
                // remainder; each step re-reads OUT so ASR keeps the sign.
                if (rem_q >= STEP_A) begin
                    out_d = coarse_dat;
                    rem_d = rem_q - STEP_A;
                end else begin
                    out_d = fine_dat;
                    rem_d = rem_q - ONE_A;
                end
                if (rem_d == '0) begin
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mode_q  <= MODE_LSL;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    assign BUSY = (state_q == ST_SHIFT);
    assign DONE = (state_q == ST_FIN);
    assign OUT  = out_q;

endmodule

// File: tb/tb_shifter_iter.sv
// Directed bench for shifter_iter (W=32, STEP=2): results, cycle-exact
// BUSY/DONE timing, ignored START, back-to-back accept and mid-op reset.
module tb_shifter_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] in_dat;
    logic [4:0]  amt;
    logic [2:0]  mode;
    logic        busy;
    logic        done;
    logic [31:0] out_dat;

    int n_checks = 0;
    int n_errors = 0;

    shifter_iter #(.W(32), .STEP(2)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .START (start),
        .IN    (in_dat),
        .AMT   (amt),
        .MODE  (mode),
        .BUSY  (busy),
        .DONE  (done),
        .OUT   (out_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge; inputs change and outputs
    // are sampled here, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] m, input logic [31:0] d, input logic [4:0] a);
        start  = 1'b1;
        mode   = m;
        in_dat = d;
        amt    = a;
    endtask

    // Accept in the current cycle t, then expect BUSY for n cycles and
    // DONE with the result in cycle t+1+n, followed by an idle cycle.
    task automatic run_op(input string tag, input logic [2:0] m, input logic [31:0] d,
                          input logic [4:0] a, input logic [31:0] exp, input int n);
        req(m, d, a);
        tick();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
            tick();
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_fin_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_out"}, out_dat, exp);
        tick();
        chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, out_dat, exp);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        in_dat = 32'd0;
        amt    = 5'd0;
        mode   = 3'd0;
        tick();
        tick();
        chk("rst_out", out_dat, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic modes, hand-computed results and N = AMT/2 + AMT%2.
        run_op("lsl5",    3'b000, 32'h0000_0001, 5'd5,  32'h0000_0020, 3);
        run_op("asr31",   3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 16);
        run_op("lsr31",   3'b001, 32'h8000_0000, 5'd31, 32'h0000_0001, 16);
        run_op("ror1",    3'b100, 32'h0000_0003, 5'd1,  32'h8000_0001, 1);
        run_op("rol3",    3'b011, 32'hC000_0000, 5'd3,  32'h0000_0006, 2);
        run_op("lsr0",    3'b001, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);
        run_op("pass7",   3'b111, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 0);
        run_op("rol8",    3'b011, 32'h1234_5678, 5'd8,  32'h3456_7812, 4);
        run_op("asr4pos", 3'b010, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 2);
        run_op("ror31",   3'b100, 32'h0000_0001, 5'd31, 32'h0000_0002, 16);
        run_op("lsl31",   3'b000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 16);

        // START pulsed mid-SHIFT must be ignored.
        req(3'b000, 32'h0000_0001, 5'd5);      // cycle t
        tick();                                 // t+1
        start = 1'b0;
        tick();                                 // t+2
        req(3'b001, 32'hFFFF_FFFF, 5'd0);
        tick();                                 // t+3
        start = 1'b0;
        chk("ign_busy", {31'd0, busy}, 32'd1);
        tick();                                 // t+4
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_out", out_dat, 32'h0000_0020);

        // Back-to-back: new accept in the FIN cycle.
        req(3'b000, 32'h0000_0001, 5'd2);      // FIN cycle = new t
        tick();                                 // t+1
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_nodone", {31'd0, done}, 32'd0);
        tick();                                 // t+2
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_out", out_dat, 32'h0000_0004);
        tick();
        chk("b2b_idle", {31'd0, done}, 32'd0);

        // Reset in the middle of an AMT=20 shift.
        req(3'b000, 32'h0000_0001, 5'd20);     // t
        tick();                                 // t+1
        start = 1'b0;
        tick();                                 // t+2
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mrst_out", out_dat, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mrst_stay", {31'd0, busy}, 32'd0);
        run_op("post_rst", 3'b000, 32'h0000_0001, 5'd20, 32'h0010_0000, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
